// File: rtl/cache_arbiter.sv
// Round-robin arbiter that puts the I-cache and D-cache line ports onto one L2 port.
// The grant is held until L2 responds, then one bubble cycle lets the owner drop its request.
module cache_arbiter #(
    parameter int unsigned LINE_W = 128,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_read,
    input  logic [ADDR_W-1:0] I_address,
    output logic [LINE_W-1:0] I_rdata,
    output logic              I_resp,
    input  logic              D_read,
    input  logic              D_write,
    input  logic [ADDR_W-1:0] D_address,
    input  logic [LINE_W-1:0] D_wdata,
    output logic [LINE_W-1:0] D_rdata,
    output logic              D_resp,
    output logic              L2_read,
    output logic              L2_write,
    output logic [ADDR_W-1:0] L2_address,
    output logic [LINE_W-1:0] L2_wdata,
    input  logic [LINE_W-1:0] L2_rdata,
    input  logic              L2_resp
);

    typedef enum logic [1:0] {StIdle, StServeI, StServeD, StDone} state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;  // 0: I-cache, 1: D-cache
    logic   i_req, d_req;

    assign i_req = I_read;
    assign d_req = D_read | D_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        I_rdata      = '0;
        I_resp       = 1'b0;
        D_rdata      = '0;
        D_resp       = 1'b0;
        L2_read      = 1'b0;
        L2_write     = 1'b0;
        L2_address   = '0;
        L2_wdata     = '0;

        unique case (state_q)
            StIdle: begin
                // On a tie the side that was not granted last wins.
                if (i_req && (!d_req || last_grant_q)) begin
                    state_d      = StServeI;
                    last_grant_d = 1'b0;
                end else if (d_req) begin
                    state_d      = StServeD;
                    last_grant_d = 1'b1;
                end
            end
            StServeI: begin
                L2_read    = I_read;
                L2_address = I_address;
                if (L2_resp) begin
                    I_resp  = 1'b1;
                    I_rdata = L2_rdata;
                    state_d = StDone;
                end
            end
            StServeD: begin
                // A writeback takes precedence over a fill when both are raised.
                L2_write   = D_write;
                L2_read    = D_read & ~D_write;
                L2_address = D_address;
                L2_wdata   = D_wdata;
                if (L2_resp) begin
                    D_resp  = 1'b1;
                    D_rdata = L2_rdata;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus random traffic, all checked cycle by cycle
// against a transaction-level model of who owns the L2 port.
module tb_cache_arbiter;

    localparam int unsigned LW = 128;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          I_read, D_read, D_write, L2_resp;
    logic [AW-1:0] I_address, D_address;
    logic [LW-1:0] D_wdata, L2_rdata;
    logic [LW-1:0] I_rdata, D_rdata, L2_wdata;
    logic          I_resp, D_resp, L2_read, L2_write;
    logic [AW-1:0] L2_address;

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .I_read     (I_read),
        .I_address  (I_address),
        .I_rdata    (I_rdata),
        .I_resp     (I_resp),
        .D_read     (D_read),
        .D_write    (D_write),
        .D_address  (D_address),
        .D_wdata    (D_wdata),
        .D_rdata    (D_rdata),
        .D_resp     (D_resp),
        .L2_read    (L2_read),
        .L2_write   (L2_write),
        .L2_address (L2_address),
        .L2_wdata   (L2_wdata),
        .L2_rdata   (L2_rdata),
        .L2_resp    (L2_resp)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: owner 0 = nobody, 1 = I, 2 = D; arbitration allowed from cycle m_free_at.
    int m_owner;
    bit m_last_d;
    int m_free_at;
    bit exp_i_resp, exp_d_resp;

    logic          obs_l2_read, obs_l2_write, obs_i_resp, obs_d_resp;
    logic [AW-1:0] obs_l2_address;
    logic [LW-1:0] obs_l2_wdata, obs_i_rdata;
    int            resp_log[$];

    function automatic logic [LW-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner    = 0;
        m_last_d   = 1'b0;
        m_free_at  = cyc;
        exp_i_resp = 1'b0;
        exp_d_resp = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        I_read    = 1'b0;
        D_read    = 1'b0;
        D_write   = 1'b0;
        L2_resp   = 1'b0;
        I_address = '0;
        D_address = '0;
        D_wdata   = '0;
        L2_rdata  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Inputs are set just after a rising edge; outputs are judged at the falling edge.
    task automatic step_cycle();
        logic          e_rd, e_wr, e_iresp, e_dresp, ir, dr;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_wdata, e_ird, e_drd;
        @(negedge clk);
        e_rd = 1'b0; e_wr = 1'b0; e_iresp = 1'b0; e_dresp = 1'b0;
        e_addr = '0; e_wdata = '0; e_ird = '0; e_drd = '0;
        if (m_owner == 1) begin
            e_rd    = I_read;
            e_addr  = I_address;
            e_iresp = L2_resp;
            e_ird   = L2_resp ? L2_rdata : '0;
        end else if (m_owner == 2) begin
            e_wr    = D_write;
            e_rd    = D_read && !D_write;
            e_addr  = D_address;
            e_wdata = D_wdata;
            e_dresp = L2_resp;
            e_drd   = L2_resp ? L2_rdata : '0;
        end
        check("L2_read", L2_read, e_rd);
        check("L2_write", L2_write, e_wr);
        check("L2_address", L2_address, e_addr);
        check("L2_wdata", L2_wdata, e_wdata);
        check("I_resp", I_resp, e_iresp);
        check("I_rdata", I_rdata, e_ird);
        check("D_resp", D_resp, e_dresp);
        check("D_rdata", D_rdata, e_drd);
        obs_l2_read = L2_read; obs_l2_write = L2_write; obs_l2_address = L2_address;
        obs_l2_wdata = L2_wdata; obs_i_resp = I_resp; obs_d_resp = D_resp; obs_i_rdata = I_rdata;
        if (I_resp) resp_log.push_back(1);
        if (D_resp) resp_log.push_back(2);
        exp_i_resp = e_iresp;
        exp_d_resp = e_dresp;
        if (m_owner != 0) begin
            if (L2_resp) begin
                m_owner   = 0;
                m_free_at = cyc + 2;
            end
        end else if (cyc >= m_free_at) begin
            ir = I_read;
            dr = D_read || D_write;
            if (ir && dr) m_owner = m_last_d ? 1 : 2;
            else if (ir)  m_owner = 1;
            else if (dr)  m_owner = 2;
            if (m_owner != 0) m_last_d = (m_owner == 2);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [LW-1:0] a5, ones, line;
        logic [1:0]    kind;
        a5   = {16{8'hA5}};
        ones = {32{4'h1}};
        rst  = 1'b1;
        model_reset();

        // Single I-cache fill with a 5-cycle L2 latency.
        do_reset();
        I_read    = 1'b1;
        I_address = 16'h1230;
        for (int k = 0; k <= 7; k++) begin
            L2_resp  = (k == 5);
            L2_rdata = (k == 5) ? a5 : rand_line();
            if (k == 6) I_read = 1'b0;
            step_cycle();
            if (k == 0) check("t1_idle_read", obs_l2_read, 1'b0);
            if (k >= 1 && k <= 5) check("t1_l2_read", obs_l2_read, 1'b1);
            if (k == 1) check("t1_addr", obs_l2_address, 16'h1230);
            if (k == 5) begin
                check("t1_i_resp", obs_i_resp, 1'b1);
                check("t1_i_rdata", obs_i_rdata, a5);
                check("t1_d_resp", obs_d_resp, 1'b0);
            end
            if (k == 6) check("t1_done_read", obs_l2_read, 1'b0);
        end

        // Simultaneous requests after reset: D first, then I after DONE and IDLE.
        do_reset();
        I_read = 1'b1; I_address = 16'h0100;
        D_read = 1'b1; D_address = 16'h0200;
        for (int k = 0; k <= 9; k++) begin
            L2_resp  = (k == 3) || (k == 7);
            L2_rdata = rand_line();
            if (k == 4) D_read = 1'b0;
            if (k == 8) I_read = 1'b0;
            step_cycle();
            if (k == 1) check("t2_d_addr", obs_l2_address, 16'h0200);
            if (k == 3) check("t2_d_resp", obs_d_resp, 1'b1);
            if (k == 3) check("t2_i_resp_off", obs_i_resp, 1'b0);
            if (k == 5) check("t2_gap_read", obs_l2_read, 1'b0);
            if (k == 6) check("t2_i_addr", obs_l2_address, 16'h0100);
            if (k == 7) check("t2_i_resp", obs_i_resp, 1'b1);
        end

        // Writeback, then write+read together.
        do_reset();
        D_write = 1'b1; D_address = 16'h4000; D_wdata = ones;
        for (int k = 0; k <= 8; k++) begin
            L2_resp  = (k == 2) || (k == 6);
            L2_rdata = rand_line();
            if (k == 3) D_write = 1'b0;
            if (k == 4) begin D_write = 1'b1; D_read = 1'b1; end
            if (k == 7) begin D_write = 1'b0; D_read = 1'b0; end
            step_cycle();
            if (k == 1 || k == 5) begin
                check("t3_write", obs_l2_write, 1'b1);
                check("t3_read", obs_l2_read, 1'b0);
            end
            if (k == 1) check("t3_wdata", obs_l2_wdata, ones);
            if (k == 1) check("t3_addr", obs_l2_address, 16'h4000);
        end

        // Both sides held continuously: grants strictly alternate D,I,D,I,D,I.
        do_reset();
        resp_log.delete();
        I_read = 1'b1; I_address = 16'h0AAA;
        D_read = 1'b1; D_address = 16'h0BBB;
        for (int k = 0; k < 60 && resp_log.size() < 6; k++) begin
            L2_resp  = (m_owner != 0);
            L2_rdata = rand_line();
            step_cycle();
        end
        check("t4_count", resp_log.size(), 6);
        for (int i = 0; i < resp_log.size(); i++)
            check("t4_order", resp_log[i], (i % 2 == 0) ? 2 : 1);
        I_read = 1'b0; D_read = 1'b0; L2_resp = 1'b0;
        step_cycle();
        step_cycle();

        // Reset in the middle of an I-cache fill.
        do_reset();
        I_read = 1'b1; I_address = 16'h7777;
        step_cycle();
        step_cycle();
        check("t5_pre_read", L2_read, 1'b1);
        rst = 1'b1;
        #1;
        check("t5_rst_read", L2_read, 1'b0);
        check("t5_rst_addr", L2_address, 16'h0000);
        check("t5_rst_i_resp", I_resp, 1'b0);
        check("t5_rst_d_resp", D_resp, 1'b0);
        I_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        L2_resp = 1'b1; L2_rdata = rand_line();
        step_cycle();
        check("t5_late_i_resp", obs_i_resp, 1'b0);
        check("t5_late_d_resp", obs_d_resp, 1'b0);
        L2_resp = 1'b0;
        step_cycle();

        // Stray L2 response while idle.
        do_reset();
        L2_resp = 1'b1; L2_rdata = rand_line();
        step_cycle();
        check("t6_read", obs_l2_read, 1'b0);
        check("t6_i_resp", obs_i_resp, 1'b0);
        check("t6_d_resp", obs_d_resp, 1'b0);
        check("t6_i_rdata", obs_i_rdata, '0);
        L2_resp = 1'b0;
        step_cycle();

        // Random traffic; requesters drop in the cycle after their response.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (I_read && exp_i_resp) begin
                I_read = 1'b0;
            end else if (!I_read && $urandom_range(0, 2) == 0) begin
                I_read    = 1'b1;
                I_address = AW'($urandom());
            end
            if ((D_read || D_write) && exp_d_resp) begin
                D_read  = 1'b0;
                D_write = 1'b0;
            end else if (!(D_read || D_write) && $urandom_range(0, 2) == 0) begin
                kind      = 2'($urandom_range(1, 3));
                D_read    = kind[0];
                D_write   = kind[1];
                D_address = AW'($urandom());
                line      = rand_line();
                D_wdata   = line;
            end
            L2_rdata = rand_line();
            L2_resp  = (m_owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
            step_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
